histogram_cdf_builder: RTL and testbench

HISTOGRAM_CDF_BUILDER -- requirements
Module: histogram_cdf_builder

---
 rtl/histogram_cdf_builder.sv | 171 +++++++++++++++++
 tb/tb_histogram_cdf_builder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_cdf_builder.sv
// Builds a pixel histogram in an external RAM, then turns it in place into an inclusive CDF.
// Optional HISTOGRAM_CDF_MIN_EN adds capture of the smallest nonzero CDF value on cdf_min.
module histogram_cdf_builder #(
  parameter int IMAGE_WIDTH      = 320,
  parameter int IMAGE_HEIGHT     = 240,
  parameter int PIXEL_WIDTH      = 8,
  parameter int HIST_DATA_WIDTH  = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT) + 1,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        is_image_RAM_available,
  input  logic [PIXEL_WIDTH-1:0]      image_RAM_data,
  output logic                        image_RAM_CE,
  output logic [IMAGE_ADDR_WIDTH-1:0] image_RAM_address,
  output logic [PIXEL_WIDTH-1:0]      histogram_RAM_address,
  output logic                        histogram_RAM_WE,
  output logic [HIST_DATA_WIDTH-1:0]  histogram_RAM_wdata,
  input  logic [HIST_DATA_WIDTH-1:0]  histogram_RAM_rdata,
  output logic                        busy,
  output logic                        done,
  output logic [HIST_DATA_WIDTH-1:0]  cdf_min
);

  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_PIX = IMAGE_ADDR_WIDTH'(NPIX - 1);
  localparam logic [PIXEL_WIDTH-1:0]      LAST_BIN = '1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, SCAN_FETCH, SCAN_READ, SCAN_WRITE, ACC_READ, ACC_WRITE, DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [IMAGE_ADDR_WIDTH-1:0] n_q, n_d;
  logic [PIXEL_WIDTH-1:0]      k_q, k_d;
  logic [PIXEL_WIDTH-1:0]      pix_q, pix_d;
  logic [HIST_DATA_WIDTH-1:0]  sum_q, sum_d;
  logic [HIST_DATA_WIDTH-1:0]  acc_value;

  assign acc_value = sum_q + histogram_RAM_rdata;
  assign busy      = (state_q != IDLE) && !rst;
  assign done      = (state_q == DONE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      pix_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      pix_q   <= pix_d;
      sum_q   <= sum_d;
    end
  end

  // stop holds every register and masks the RAM strobes; addresses stay driven
  // so the synchronous histogram read data remains valid across the freeze.
  always_comb begin
    state_d               = state_q;
    n_d                   = n_q;
    k_d                   = k_q;
    pix_d                 = pix_q;
    sum_d                 = sum_q;
    image_RAM_CE          = 1'b0;
    image_RAM_address     = '0;
    histogram_RAM_address = '0;
    histogram_RAM_WE      = 1'b0;
    histogram_RAM_wdata   = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_d = CLEAR;
            k_d     = '0;
          end
        end
        CLEAR: begin
          histogram_RAM_address = k_q;
          histogram_RAM_WE      = !stop;
          if (!stop) begin
            k_d = k_q + 1'b1;
            if (k_q == LAST_BIN) begin
              state_d = SCAN_FETCH;
              n_d     = '0;
            end
          end
        end
        SCAN_FETCH: begin
          image_RAM_CE      = !stop;
          image_RAM_address = n_q;
          if (!stop && is_image_RAM_available) state_d = SCAN_READ;
        end
        SCAN_READ: begin
          histogram_RAM_address = image_RAM_data;
          if (!stop) begin
            pix_d   = image_RAM_data;
            state_d = SCAN_WRITE;
          end
        end
        SCAN_WRITE: begin
          histogram_RAM_address = pix_q;
          histogram_RAM_WE      = !stop;
          histogram_RAM_wdata   = histogram_RAM_rdata + HIST_DATA_WIDTH'(1);
          if (!stop) begin
            if (n_q == LAST_PIX) begin
              state_d = ACC_READ;
              k_d     = '0;
              sum_d   = '0;
            end else begin
              n_d     = n_q + 1'b1;
              state_d = SCAN_FETCH;
            end
          end
        end
        ACC_READ: begin
          histogram_RAM_address = k_q;
          if (!stop) state_d = ACC_WRITE;
        end
        ACC_WRITE: begin
          histogram_RAM_address = k_q;
          histogram_RAM_WE      = !stop;
          histogram_RAM_wdata   = acc_value;
          if (!stop) begin
            sum_d = acc_value;
            if (k_q == LAST_BIN) begin
              state_d = DONE;
            end else begin
              k_d     = k_q + 1'b1;
              state_d = ACC_READ;
            end
          end
        end
        DONE: begin
          if (!stop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef HISTOGRAM_CDF_MIN_EN
  logic [HIST_DATA_WIDTH-1:0] cdf_min_q, cdf_min_d;

  // The CDF is monotonic, so the first nonzero write is also the smallest one.
  always_comb begin
    cdf_min_d = cdf_min_q;
    if (!stop) begin
      if (state_q == IDLE && start)
        cdf_min_d = '0;
      else if (state_q == ACC_WRITE && cdf_min_q == '0 && acc_value != '0)
        cdf_min_d = acc_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cdf_min_q <= '0;
    else     cdf_min_q <= cdf_min_d;
  end

  assign cdf_min = cdf_min_q;
`else
  assign cdf_min = '0;
`endif

endmodule

// File: tb/tb_histogram_cdf_builder.sv
// Directed bench for histogram_cdf_builder with a 4x2 image and 8-bit pixels.
// Models both RAMs, checks latency, stall/stop/reset behaviour and the resulting CDF.
module tb_histogram_cdf_builder;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int PW  = 8;
  localparam int NB  = 256;
  localparam int HDW = 4;
  localparam int IAW = 3;
  localparam int BASE_LATENCY = NB + 3*W*H + 2*NB + 1;
`ifdef HISTOGRAM_CDF_MIN_EN
  localparam int CDF_EN = 1;
`else
  localparam int CDF_EN = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           stop;
  logic           avail;
  logic [PW-1:0]  img_data = '0;
  logic           img_ce;
  logic [IAW-1:0] img_addr;
  logic [PW-1:0]  hist_addr;
  logic           hist_we;
  logic [HDW-1:0] hist_wdata;
  logic [HDW-1:0] hist_rdata = '0;
  logic           busy;
  logic           done;
  logic [HDW-1:0] cdf_min;

  logic [PW-1:0]  image_mem [0:W*H-1];
  logic [HDW-1:0] hist_mem  [0:NB-1];

  int vec_count = 0;
  int miscompares = 0;

  typedef struct {
    int img_set;
    int bin;
    int expected;
  } vec_t;
  vec_t vecs [0:14];

  histogram_cdf_builder #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .is_image_RAM_available(avail),
    .image_RAM_data(img_data),
    .image_RAM_CE(img_ce),
    .image_RAM_address(img_addr),
    .histogram_RAM_address(hist_addr),
    .histogram_RAM_WE(hist_we),
    .histogram_RAM_wdata(hist_wdata),
    .histogram_RAM_rdata(hist_rdata),
    .busy(busy),
    .done(done),
    .cdf_min(cdf_min)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (img_ce && avail) img_data <= image_mem[img_addr];
    if (hist_we) hist_mem[hist_addr] <= hist_wdata;
    hist_rdata <= hist_mem[hist_addr];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic loadImage(input int img_set);
    for (int i = 0; i < W*H; i++) image_mem[i] = 8'h80;
    if (img_set == 1) begin
      image_mem[0] = 8'd0;   image_mem[1] = 8'd0;
      image_mem[2] = 8'd1;   image_mem[3] = 8'd255;
      image_mem[4] = 8'd3;   image_mem[5] = 8'd3;
      image_mem[6] = 8'd3;   image_mem[7] = 8'd200;
    end
  endtask

  function automatic int modelCdf(input int bin);
    int cnt = 0;
    for (int i = 0; i < W*H; i++) if (int'(image_mem[i]) <= bin) cnt++;
    return cnt;
  endfunction

  task automatic checkCdf(input int img_set, input int exp_min);
    for (int v = 0; v < 15; v++)
      if (vecs[v].img_set == img_set)
        checkOutput($sformatf("table_set%0d_bin%0d", img_set, vecs[v].bin),
                    int'(hist_mem[vecs[v].bin]), vecs[v].expected);
    for (int b = 0; b < NB; b++)
      checkOutput($sformatf("model_bin%0d", b), int'(hist_mem[b]), modelCdf(b));
    checkOutput("cdf_min", int'(cdf_min), CDF_EN ? exp_min : 0);
  endtask

  // One build from a start pulse; optional availability stall, stop window,
  // abort via reset, and stray start pulses while busy. Negative values disable.
  task automatic applyStimulus(input int stall_pix, input int stall_len,
                               input int stop_at, input int stop_len,
                               input int abort_at, input int pulse_a, input int pulse_b,
                               output int cycles, output int done_seen);
    int stall_left;
    int stop_left;
    int frozen_addr;
    bit finished;
    stall_left  = stall_len;
    stop_left   = 0;
    frozen_addr = 0;
    done_seen   = 0;
    finished    = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    checkOutput("busy_first_cycle", int'(busy), 1);
    while (!finished && cycles < 2000) begin
      if (done) begin
        done_seen++;
        finished = 1'b1;
      end else if (cycles == abort_at) begin
        checkOutput("we_before_abort", int'(hist_we), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("busy_after_rst", int'(busy), 0);
        checkOutput("done_after_rst", int'(done), 0);
        finished = 1'b1;
      end else begin
        if (stop) begin
          checkOutput("stop_we", int'(hist_we), 0);
          checkOutput("stop_addr", int'(hist_addr), frozen_addr);
        end
        if (cycles == stop_at) begin
          stop_left   = stop_len;
          frozen_addr = int'(hist_addr);
        end
        stop = (stop_left > 0);
        if (stop_left > 0) stop_left--;
        if (stall_left > 0 && (stall_left < stall_len || (img_ce && int'(img_addr) == stall_pix))) begin
          checkOutput("stall_ce", int'(img_ce), 1);
          checkOutput("stall_addr", int'(img_addr), stall_pix);
          avail = 1'b0;
          stall_left--;
        end else begin
          avail = 1'b1;
        end
        start = (cycles == pulse_a || cycles == pulse_b);
        @(posedge clk); #1;
        cycles++;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    avail = 1'b1;
    if (!finished) checkOutput("done_timeout", cycles, -1);
    if (abort_at < 0) begin
      repeat (20) begin
        @(posedge clk); #1;
        if (done) done_seen++;
      end
      checkOutput("busy_after_done", int'(busy), 0);
    end
  endtask

  int cycles;
  int done_seen;

  initial begin
    vecs[0]  = '{0, 8'h00, 0};
    vecs[1]  = '{0, 8'h40, 0};
    vecs[2]  = '{0, 8'h7F, 0};
    vecs[3]  = '{0, 8'h80, 8};
    vecs[4]  = '{0, 8'hC0, 8};
    vecs[5]  = '{0, 8'hFF, 8};
    vecs[6]  = '{1, 0,   2};
    vecs[7]  = '{1, 1,   3};
    vecs[8]  = '{1, 2,   3};
    vecs[9]  = '{1, 3,   6};
    vecs[10] = '{1, 4,   6};
    vecs[11] = '{1, 199, 6};
    vecs[12] = '{1, 200, 7};
    vecs[13] = '{1, 254, 7};
    vecs[14] = '{1, 255, 8};

    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    avail = 1'b1;
    for (int b = 0; b < NB; b++) hist_mem[b] = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_ce", int'(img_ce), 0);
    checkOutput("rst_we", int'(hist_we), 0);
    checkOutput("rst_img_addr", int'(img_addr), 0);
    checkOutput("rst_hist_addr", int'(hist_addr), 0);
    checkOutput("rst_wdata", int'(hist_wdata), 0);
    checkOutput("rst_cdf_min", int'(cdf_min), 0);
    rst = 1'b0;

    $display("[TB] uniform image build");
    loadImage(0);
    applyStimulus(-1, 0, -1, 0, -1, -1, -1, cycles, done_seen);
    checkOutput("latency_uniform", cycles, BASE_LATENCY);
    checkOutput("done_count_uniform", done_seen, 1);
    checkCdf(0, 8);

    $display("[TB] mixed image build");
    loadImage(1);
    applyStimulus(-1, 0, -1, 0, -1, -1, -1, cycles, done_seen);
    checkOutput("latency_mixed", cycles, BASE_LATENCY);
    checkOutput("done_count_mixed", done_seen, 1);
    checkCdf(1, 2);

    $display("[TB] availability stall on pixel 2");
    applyStimulus(2, 5, -1, 0, -1, -1, -1, cycles, done_seen);
    checkOutput("latency_stall", cycles, BASE_LATENCY + 5);
    checkOutput("done_count_stall", done_seen, 1);
    checkCdf(1, 2);

    $display("[TB] stop during accumulation");
    applyStimulus(-1, 0, NB + 3*W*H + 100, 10, -1, -1, -1, cycles, done_seen);
    checkOutput("latency_stop", cycles, BASE_LATENCY + 10);
    checkOutput("done_count_stop", done_seen, 1);
    checkCdf(1, 2);

    $display("[TB] reset during scan write, then rebuild with stray starts");
    loadImage(0);
    applyStimulus(-1, 0, -1, 0, NB + 6, -1, -1, cycles, done_seen);
    checkOutput("abort_no_done", done_seen, 0);
    loadImage(1);
    applyStimulus(-1, 0, -1, 0, -1, 100, 600, cycles, done_seen);
    checkOutput("latency_rebuild", cycles, BASE_LATENCY);
    checkOutput("done_count_rebuild", done_seen, 1);
    checkCdf(1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
